hazard_fwd_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage RV32I pipeline. It generates the 2-bit select codes for the two EX-stage 3:1 operand muxes (SrcA/SrcB forwarding), the load-use stall, and the branch flush.
- Keeps its own shadow copy of the destination/write-enable/load info for the EX, MEM and WB stages, so the datapath supplies only decode-stage fields plus the branch-taken strobe.
- Sits beside the datapath and drives the mux select pins and pipeline-register enables/clears.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/fwd_sel_unit.sv | 39 +++
 rtl/hazard_fwd_ctrl.sv | 151 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I hazard/forwarding controller.
//   fwd_sel_t : EX-stage operand mux select (regfile / WB result / MEM ALU result)
//   REG_AW    : register address width
//   ZERO_REG  : register index that is never forwarded or stalled on
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned ZERO_REG = 0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

endpackage : hazard_pkg

// File: rtl/fwd_sel_unit.sv
// -----------------------------------------------------------------------------
// fwd_sel_unit
// Combinational forwarding select for one EX-stage source operand.
// Ports:
//   rs_e_i        EX-stage source register
//   rd_m_i        MEM-stage destination register
//   reg_write_m_i MEM-stage instruction writes rd
//   rd_w_i        WB-stage destination register
//   reg_write_w_i WB-stage instruction writes rd
//   sel_o         mux select; the MEM stage wins when both stages match
// -----------------------------------------------------------------------------
module fwd_sel_unit
   import hazard_pkg::*;
#(
   parameter int unsigned AW       = hazard_pkg::REG_AW,
   parameter int unsigned ZERO_IDX = hazard_pkg::ZERO_REG
) (
   input  logic [AW-1:0] rs_e_i,
   input  logic [AW-1:0] rd_m_i,
   input  logic          reg_write_m_i,
   input  logic [AW-1:0] rd_w_i,
   input  logic          reg_write_w_i,
   output fwd_sel_t      sel_o
);

   localparam logic [AW-1:0] ZR = AW'(ZERO_IDX);

   always_comb begin
      sel_o = FWD_RF;
      if (rs_e_i != ZR) begin
         if (reg_write_m_i && (rd_m_i == rs_e_i)) begin
            sel_o = FWD_MEM;
         end else if (reg_write_w_i && (rd_w_i == rs_e_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule : fwd_sel_unit

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard and forwarding controller for a 5-stage RV32I pipeline. Keeps shadow
// copies of the EX/MEM/WB destination info so the datapath only supplies
// decode-stage fields plus the branch-taken strobe.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d      decode-stage register fields
//   reg_write_d, is_load_d  decode-stage instruction attributes
//   pc_src_e                branch/jump taken (resolved in EX)
//   forward_a_e/forward_b_e EX operand mux selects (00 RF, 01 WB, 10 MEM)
//   stall_f, stall_d        hold PC / IF-ID on load-use
//   flush_d, flush_e        clear IF-ID / ID-EX
// Optional macro HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt performance
// counters (32-bit, wrapping).
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_AW   = hazard_pkg::REG_AW,
   parameter int unsigned ZERO_REG = hazard_pkg::ZERO_REG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              reg_write_d,
   input  logic              is_load_d,
   input  logic              pc_src_e,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
`endif
);

   localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

   // EX-stage shadow state
   logic [REG_AW-1:0] rs1_e_q, rs1_e_d;
   logic [REG_AW-1:0] rs2_e_q, rs2_e_d;
   logic [REG_AW-1:0] rd_e_q,  rd_e_d;
   logic              reg_write_e_q, reg_write_e_d;
   logic              is_load_e_q,   is_load_e_d;
   // MEM / WB shadow state
   logic [REG_AW-1:0] rd_m_q, rd_w_q;
   logic              reg_write_m_q, reg_write_w_q;

   logic     pc_src_v;
   logic     lw_stall;
   fwd_sel_t sel_a, sel_b;

   // Outputs must read zero while reset is held, whatever pc_src_e does.
   assign pc_src_v = pc_src_e & rst_n;

   assign lw_stall = is_load_e_q && (rd_e_q != ZR) &&
                     ((rd_e_q == rs1_d) || (rd_e_q == rs2_d)) && !pc_src_v;

   assign stall_f = lw_stall;
   assign stall_d = lw_stall;
   assign flush_d = pc_src_v;
   assign flush_e = lw_stall | pc_src_v;

   fwd_sel_unit #(.AW(REG_AW), .ZERO_IDX(ZERO_REG)) u_fwd_a (
      .rs_e_i        (rs1_e_q),
      .rd_m_i        (rd_m_q),
      .reg_write_m_i (reg_write_m_q),
      .rd_w_i        (rd_w_q),
      .reg_write_w_i (reg_write_w_q),
      .sel_o         (sel_a)
   );

   fwd_sel_unit #(.AW(REG_AW), .ZERO_IDX(ZERO_REG)) u_fwd_b (
      .rs_e_i        (rs2_e_q),
      .rd_m_i        (rd_m_q),
      .reg_write_m_i (reg_write_m_q),
      .rd_w_i        (rd_w_q),
      .reg_write_w_i (reg_write_w_q),
      .sel_o         (sel_b)
   );

   assign forward_a_e = 2'(sel_a);
   assign forward_b_e = 2'(sel_b);

   // A flushed EX slot becomes a bubble that never writes, so it never forwards.
   always_comb begin
      rs1_e_d       = rs1_d;
      rs2_e_d       = rs2_d;
      rd_e_d        = rd_d;
      reg_write_e_d = reg_write_d;
      is_load_e_d   = is_load_d;
      if (flush_e) begin
         rs1_e_d       = '0;
         rs2_e_d       = '0;
         rd_e_d        = '0;
         reg_write_e_d = 1'b0;
         is_load_e_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e_q       <= '0;
         rs2_e_q       <= '0;
         rd_e_q        <= '0;
         reg_write_e_q <= 1'b0;
         is_load_e_q   <= 1'b0;
         rd_m_q        <= '0;
         reg_write_m_q <= 1'b0;
         rd_w_q        <= '0;
         reg_write_w_q <= 1'b0;
      end else begin
         rs1_e_q       <= rs1_e_d;
         rs2_e_q       <= rs2_e_d;
         rd_e_q        <= rd_e_d;
         reg_write_e_q <= reg_write_e_d;
         is_load_e_q   <= is_load_e_d;
         rd_m_q        <= rd_e_q;
         reg_write_m_q <= reg_write_e_q;
         rd_w_q        <= rd_m_q;
         reg_write_w_q <= reg_write_m_q;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (lw_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (pc_src_v) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   // Performance counters not built.
`endif

endmodule : hazard_fwd_ctrl

// File: tb/tb_hazard_fwd_ctrl.sv
module tb_hazard_fwd_ctrl;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       reg_write_d, is_load_d, pc_src_e;
   logic [1:0] forward_a_e, forward_b_e;
   logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
`endif

   hazard_fwd_ctrl #(.REG_AW(5), .ZERO_REG(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd_d        (rd_d),
      .reg_write_d (reg_write_d),
      .is_load_d   (is_load_d),
      .pc_src_e    (pc_src_e),
      .forward_a_e (forward_a_e),
      .forward_b_e (forward_b_e),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .flush_e     (flush_e)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } instr_t;

   localparam instr_t BUBBLE = '0;

   instr_t pipe[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   int     exp_scnt = 0;
   int     exp_fcnt = 0;
   logic [1:0] last_fa, last_fb;
   logic       last_sf, last_sd, last_fd, last_fe;

   // Youngest older producer of rs wins; x0 never forwards.
   function automatic logic [1:0] model_fwd(input logic [4:0] rs);
      for (int age = 1; age <= 2; age++) begin
         if (rs != 5'd0 && pipe[age].wr && pipe[age].rd == rs)
            return (age == 1) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back(BUBBLE);
      exp_scnt = 0;
      exp_fcnt = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_fa"}, 32'(forward_a_e), 32'd0);
      chk({tag, "_fb"}, 32'(forward_b_e), 32'd0);
      chk({tag, "_sf"}, 32'(stall_f), 32'd0);
      chk({tag, "_sd"}, 32'(stall_d), 32'd0);
      chk({tag, "_fd"}, 32'(flush_d), 32'd0);
      chk({tag, "_fe"}, 32'(flush_e), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
      chk({tag, "_scnt"}, stall_cnt, 32'd0);
      chk({tag, "_fcnt"}, flush_cnt, 32'd0);
`endif
   endtask

   // One cycle: drive decode fields, check at the negedge, advance the model.
   task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic l, input logic p);
      logic   lw;
      instr_t nxt;
      rs1_d = a; rs2_d = b; rd_d = d;
      reg_write_d = w; is_load_d = l; pc_src_e = p;
      @(negedge clk);
      lw = pipe[0].ld && pipe[0].rd != 5'd0 && (pipe[0].rd == a || pipe[0].rd == b) && !p;
      chk("fwd_a", 32'(forward_a_e), 32'(model_fwd(pipe[0].rs1)));
      chk("fwd_b", 32'(forward_b_e), 32'(model_fwd(pipe[0].rs2)));
      chk("stall_f", 32'(stall_f), 32'(lw));
      chk("stall_d", 32'(stall_d), 32'(lw));
      chk("flush_d", 32'(flush_d), 32'(p));
      chk("flush_e", 32'(flush_e), 32'(lw | p));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(exp_scnt));
      chk("flush_cnt", flush_cnt, 32'(exp_fcnt));
`endif
      last_fa = forward_a_e; last_fb = forward_b_e;
      last_sf = stall_f; last_sd = stall_d;
      last_fd = flush_d; last_fe = flush_e;
      if (lw) exp_scnt++;
      if (p)  exp_fcnt++;
      nxt = (lw || p) ? BUBBLE : '{rs1: a, rs2: b, rd: d, wr: w, ld: l};
      @(posedge clk);
      void'(pipe.pop_back());
      pipe.push_front(nxt);
      #1;
   endtask

   task automatic nop();
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_model();
      // Reset held with hazardous-looking inputs, including a taken branch.
      rst_n = 1'b0;
      rs1_d = 5'd7; rs2_d = 5'd7; rd_d = 5'd7;
      reg_write_d = 1'b1; is_load_d = 1'b1; pc_src_e = 1'b1;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      repeat (3) nop();
      chk("nop_fa", 32'(last_fa), 32'd0);

      // Back-to-back dependency: MEM forwarding.
      step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      step(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
      nop();
      chk("dir_fwd_mem", 32'(last_fa), 32'd2);
      repeat (2) nop();

      // One NOP between: WB forwarding.
      step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      nop();
      step(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
      nop();
      chk("dir_fwd_wb", 32'(last_fa), 32'd1);
      repeat (2) nop();

      // Same rd in MEM and WB: MEM wins.
      step(5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      step(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
      step(5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0);
      nop();
      chk("dir_mem_over_wb", 32'(last_fa), 32'd2);
      repeat (2) nop();

      // Writes to x0 never forward; lw x0 never stalls.
      step(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      step(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      step(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      nop();
      chk("dir_x0_fa", 32'(last_fa), 32'd0);
      chk("dir_x0_fb", 32'(last_fb), 32'd0);
      step(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
      chk("dir_lw_x0_nostall", 32'(last_sf), 32'd0);
      repeat (2) nop();

      // Load-use: one stall cycle, then WB forwarding on both operands.
      step(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      step(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
      chk("dir_lu_sf", 32'(last_sf), 32'd1);
      chk("dir_lu_sd", 32'(last_sd), 32'd1);
      chk("dir_lu_fe", 32'(last_fe), 32'd1);
      step(5'd7, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
      chk("dir_lu_once", 32'(last_sf), 32'd0);
      nop();
      chk("dir_lu_fa", 32'(last_fa), 32'd1);
      chk("dir_lu_fb", 32'(last_fb), 32'd1);
      repeat (2) nop();

      // Taken branch: flush now, bubble next cycle.
      step(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1);
      chk("dir_br_fd", 32'(last_fd), 32'd1);
      chk("dir_br_fe", 32'(last_fe), 32'd1);
      step(5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
      nop();
      chk("dir_br_bubble_fa", 32'(last_fa), 32'd0);
      // Branch coincident with load-use: stall masked.
      step(5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      step(5'd7, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
      chk("dir_br_lu_sf", 32'(last_sf), 32'd0);
      chk("dir_br_lu_fe", 32'(last_fe), 32'd1);
      repeat (2) nop();

      // Randomized traffic over a small register window to provoke hazards.
      for (int i = 0; i < 300; i++) begin
         step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 9) < 1));
         if (i == 150) begin
            // Asynchronous reset mid-stream, away from the clock edge.
            rst_n = 1'b0;
            #2;
            check_all_zero("midreset");
            reset_model();
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_hazard_fwd_ctrl
